// File: rtl/determinant_nxn_seq.sv
// Sequential fraction-free (Bareiss) determinant engine with row-swap pivoting.
// Build option DET_SATURATE_EN: clamp det on overflow instead of wrapping it.
module determinant_nxn_seq #(
    parameter int DATA_W = 8,
    parameter int MAX_N  = 5,
    parameter int ACC_W  = 48
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [2:0]                    size,
    input  logic [MAX_N*MAX_N*DATA_W-1:0] A_flat,
    output logic [DATA_W-1:0]             det,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow_flag,
    output logic                          size_err
);
    localparam int IW = 3;
    localparam int PW = 2 * ACC_W;
    localparam logic [7:0]              DIV_STEPS = 8'(PW);
    localparam logic [IW-1:0]           MAX_N3    = IW'(MAX_N);
    localparam logic signed [ACC_W-1:0] ONE       = ACC_W'(32'sd1);
    localparam logic signed [ACC_W-1:0] DMAX      = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] DMIN      = ~DMAX;

    typedef enum logic [3:0] {
        S_IDLE, S_PIVOT, S_SCAN, S_SWAP, S_MUL, S_DIV, S_NEXT, S_FINAL, S_DONE
    } state_t;

    state_t                  r_state, w_next;
    logic signed [ACC_W-1:0] r_m [MAX_N][MAX_N];
    logic signed [ACC_W-1:0] w_a [MAX_N][MAX_N];
    logic [IW-1:0]           r_n, r_k, r_i, r_j, r_row;
    logic signed [ACC_W-1:0] r_prev;
    logic                    r_neg;
    logic [PW-1:0]           r_dq;
    logic [ACC_W-1:0]        r_rem, r_div;
    logic                    r_qneg;
    logic [7:0]              r_cnt;
    logic [DATA_W-1:0]       r_det;
    logic                    r_ovf, r_size_err;

    for (genvar gr = 0; gr < MAX_N; gr++) begin : g_row
        for (genvar gc = 0; gc < MAX_N; gc++) begin : g_col
            assign w_a[gr][gc] = ACC_W'($signed(A_flat[(gr*MAX_N+gc)*DATA_W +: DATA_W]));
        end
    end

    logic                    w_size_bad, w_pivot_nz, w_scan_nz, w_row_end, w_last_elem;
    logic                    w_prev_one, w_div_last, w_ge;
    logic [IW-1:0]           w_nm1, w_k1;
    logic signed [PW-1:0]    w_ij, w_kk, w_ik, w_kj, w_t;
    logic [PW-1:0]           w_t_abs, w_dq_nxt;
    logic [ACC_W-1:0]        w_prev_abs, w_sub, w_rem_nxt, w_quo;
    logic [ACC_W:0]          w_shift;
    logic signed [ACC_W-1:0] w_div_res, w_full;

    assign w_size_bad  = (size == 3'd0) || (size > MAX_N3);
    assign w_nm1       = r_n - 3'd1;
    assign w_k1        = r_k + 3'd1;
    assign w_pivot_nz  = r_m[r_k][r_k] != {ACC_W{1'b0}};
    assign w_scan_nz   = r_m[r_row][r_k] != {ACC_W{1'b0}};
    assign w_row_end   = (r_j == w_nm1);
    assign w_last_elem = w_row_end && (r_i == w_nm1);
    assign w_prev_one  = (r_prev == ONE);
    assign w_div_last  = (r_cnt == 8'd1);

    // Cross-multiply at double width so the product of two minors cannot overflow.
    assign w_ij    = PW'(r_m[r_i][r_j]);
    assign w_kk    = PW'(r_m[r_k][r_k]);
    assign w_ik    = PW'(r_m[r_i][r_k]);
    assign w_kj    = PW'(r_m[r_k][r_j]);
    assign w_t     = w_ij * w_kk - w_ik * w_kj;
    assign w_t_abs = w_t[PW-1] ? -w_t : w_t;
    assign w_prev_abs = r_prev[ACC_W-1] ? -r_prev : r_prev;

    // Restoring division on magnitudes; the quotient is exact so only its low ACC_W bits matter.
    assign w_shift   = {r_rem, r_dq[PW-1]};
    assign w_ge      = (w_shift >= {1'b0, r_div});
    assign w_sub     = w_shift[ACC_W-1:0] - r_div;
    assign w_rem_nxt = w_ge ? w_sub : w_shift[ACC_W-1:0];
    assign w_dq_nxt  = {r_dq[PW-2:0], w_ge};
    assign w_quo     = w_dq_nxt[ACC_W-1:0];
    assign w_div_res = r_qneg ? -w_quo : w_quo;
    assign w_full    = r_neg ? -r_m[w_nm1][w_nm1] : r_m[w_nm1][w_nm1];

    function automatic logic [DATA_W-1:0] f_det(input logic signed [ACC_W-1:0] full);
`ifdef DET_SATURATE_EN
        if (full > DMAX)      f_det = DMAX[DATA_W-1:0];
        else if (full < DMIN) f_det = DMIN[DATA_W-1:0];
        else                  f_det = full[DATA_W-1:0];
`else
        f_det = full[DATA_W-1:0];
`endif
    endfunction

    // State register.
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (!start)                w_next = S_IDLE;
                     else if (w_size_bad)       w_next = S_DONE;
                     else if (size == 3'd1)     w_next = S_FINAL;
                     else                       w_next = S_PIVOT;
            S_PIVOT: w_next = w_pivot_nz ? S_MUL : S_SCAN;
            S_SCAN:  if (w_scan_nz)             w_next = S_SWAP;
                     else if (r_row == w_nm1)   w_next = S_DONE;
                     else                       w_next = S_SCAN;
            S_SWAP:  w_next = S_MUL;
            S_MUL:   if (!w_prev_one)           w_next = S_DIV;
                     else                       w_next = w_last_elem ? S_NEXT : S_MUL;
            S_DIV:   if (!w_div_last)           w_next = S_DIV;
                     else                       w_next = w_last_elem ? S_NEXT : S_MUL;
            S_NEXT:  w_next = (w_k1 == w_nm1) ? S_FINAL : S_PIVOT;
            S_FINAL: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_IDLE:  busy = 1'b0;
            S_DONE:  done = 1'b1;
            default: busy = 1'b1;
        endcase
    end

    // Working matrix, loop indices, divider and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < MAX_N; r++)
                for (int c = 0; c < MAX_N; c++)
                    r_m[IW'(r)][IW'(c)] <= {ACC_W{1'b0}};
            r_n <= 3'd0; r_k <= 3'd0; r_i <= 3'd0; r_j <= 3'd0; r_row <= 3'd0;
            r_prev <= ONE; r_neg <= 1'b0; r_qneg <= 1'b0; r_cnt <= 8'd0;
            r_dq <= {PW{1'b0}}; r_rem <= {ACC_W{1'b0}}; r_div <= {ACC_W{1'b0}};
            r_det <= {DATA_W{1'b0}}; r_ovf <= 1'b0; r_size_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    for (int r = 0; r < MAX_N; r++)
                        for (int c = 0; c < MAX_N; c++)
                            r_m[IW'(r)][IW'(c)] <= (IW'(r) < size && IW'(c) < size) ?
                                                   w_a[IW'(r)][IW'(c)] : {ACC_W{1'b0}};
                    r_n <= size; r_k <= 3'd0; r_prev <= ONE; r_neg <= 1'b0;
                    if (w_size_bad) begin
                        r_det <= {DATA_W{1'b0}}; r_ovf <= 1'b0; r_size_err <= 1'b1;
                    end
                end
                S_PIVOT: begin
                    r_row <= w_k1; r_i <= w_k1; r_j <= w_k1;
                end
                S_SCAN: if (!w_scan_nz) begin
                    r_row <= r_row + 3'd1;
                    if (r_row == w_nm1) begin
                        r_det <= {DATA_W{1'b0}}; r_ovf <= 1'b0; r_size_err <= 1'b0;
                    end
                end
                S_SWAP: begin
                    for (int c = 0; c < MAX_N; c++) begin
                        r_m[r_k][IW'(c)]   <= r_m[r_row][IW'(c)];
                        r_m[r_row][IW'(c)] <= r_m[r_k][IW'(c)];
                    end
                    r_neg <= ~r_neg;
                end
                S_MUL: if (w_prev_one) begin
                    r_m[r_i][r_j] <= w_t[ACC_W-1:0];
                    r_i <= w_row_end ? r_i + 3'd1 : r_i;
                    r_j <= w_row_end ? w_k1 : r_j + 3'd1;
                end else begin
                    r_dq <= w_t_abs; r_rem <= {ACC_W{1'b0}}; r_div <= w_prev_abs;
                    r_qneg <= w_t[PW-1] ^ r_prev[ACC_W-1]; r_cnt <= DIV_STEPS;
                end
                S_DIV: begin
                    r_dq <= w_dq_nxt; r_rem <= w_rem_nxt; r_cnt <= r_cnt - 8'd1;
                    if (w_div_last) begin
                        r_m[r_i][r_j] <= w_div_res;
                        r_i <= w_row_end ? r_i + 3'd1 : r_i;
                        r_j <= w_row_end ? w_k1 : r_j + 3'd1;
                    end
                end
                S_NEXT: begin
                    r_prev <= r_m[r_k][r_k];
                    r_k    <= w_k1;
                end
                S_FINAL: begin
                    r_det      <= f_det(w_full);
                    r_ovf      <= (w_full > DMAX) || (w_full < DMIN);
                    r_size_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign det           = r_det;
    assign overflow_flag = r_ovf;
    assign size_err      = r_size_err;
endmodule

// File: tb/tb_determinant_nxn_seq.sv
// Randomised bench for determinant_nxn_seq: expectations come from a permutation-sum
// (Leibniz) determinant model, queued at start and checked whenever done pulses.
module tb_determinant_nxn_seq;
    localparam int DW = 8;
    localparam int MN = 5;

    logic                  clock = 1'b0;
    logic                  reset, start;
    logic [2:0]            size;
    logic [MN*MN*DW-1:0]   A_flat;
    logic [DW-1:0]         det;
    logic                  busy, done, overflow_flag, size_err;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0] det;
        logic       ovf;
        logic       serr;
    } exp_t;
    exp_t exp_q[$];
    exp_t cmp_e;
    int   mt[5][5];

    determinant_nxn_seq #(.DATA_W(DW), .MAX_N(MN), .ACC_W(48)) dut (
        .clock(clock), .reset(reset), .start(start), .size(size), .A_flat(A_flat),
        .det(det), .busy(busy), .done(done), .overflow_flag(overflow_flag), .size_err(size_err)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Leibniz sum over all permutations of 0..n-1.
    function automatic longint model_det(input int n, input int m[5][5]);
        longint total = 0;
        longint prod;
        int     pw = 1;
        int     perm[5];
        int     code, inv;
        bit     ok;
        for (int i = 0; i < n; i++) pw *= n;
        for (int c = 0; c < pw; c++) begin
            code = c;
            for (int i = 0; i < n; i++) begin perm[i] = code % n; code /= n; end
            ok = 1'b1; inv = 0;
            for (int i = 0; i < n; i++)
                for (int j = i + 1; j < n; j++)
                    if (perm[i] == perm[j]) ok = 1'b0;
                    else if (perm[i] > perm[j]) inv++;
            if (ok) begin
                prod = 1;
                for (int i = 0; i < n; i++) prod *= m[i][perm[i]];
                total += (inv % 2 == 1) ? -prod : prod;
            end
        end
        return total;
    endfunction

    function automatic exp_t model_job(input int n, input int m[5][5]);
        exp_t   e;
        longint full;
        if (n < 1 || n > MN) begin
            e.det = 8'h00; e.ovf = 1'b0; e.serr = 1'b1;
        end else begin
            full   = model_det(n, m);
            e.serr = 1'b0;
            e.ovf  = (full > 127) || (full < -128);
`ifdef DET_SATURATE_EN
            if (full > 127)       e.det = 8'h7F;
            else if (full < -128) e.det = 8'h80;
            else                  e.det = full[7:0];
`else
            e.det = full[7:0];
`endif
        end
        return e;
    endfunction

    task automatic load(input int n, input int m[5][5]);
        size = 3'(n);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                A_flat[(r*5+c)*8 +: 8] = 8'(m[r][c]);
    endtask

    task automatic scramble();
        size = 3'($urandom_range(0, 7));
        for (int w = 0; w < MN*MN; w++) A_flat[w*8 +: 8] = 8'($urandom);
    endtask

    task automatic clr();
        for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) mt[r][c] = 0;
    endtask

    task automatic set_row(input int r, input int a0, input int a1, input int a2,
                           input int a3, input int a4);
        mt[r][0] = a0; mt[r][1] = a1; mt[r][2] = a2; mt[r][3] = a3; mt[r][4] = a4;
    endtask

    // Issue one job, optionally poking start while busy and during the done cycle.
    task automatic run_job(input int n, input bit poke, input bit done_poke,
                           output logic [7:0] d, output logic o, output logic s, output int lat);
        @(negedge clock);
        load(n, mt);
        start = 1'b1;
        exp_q.push_back(model_job(n, mt));
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
            start = (poke && lat == 3) ? 1'b1 : 1'b0;
            if (lat == 1 || start) scramble();
            if (lat == 1 && !done) check("busy_after_start", busy, 1);
        end while (!done && lat < 5000);
        start = 1'b0;
        if (!done) begin
            check("done_timeout", done, 1);
            exp_q.delete();
        end
        d = det; o = overflow_flag; s = size_err;
        if (done_poke) begin
            size = 3'd2;
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            check("start_in_done_ignored_busy", busy, 0);
        end
    endtask

    // Every done pulse is checked against the oldest outstanding expectation.
    always @(negedge clock) begin
        if (done) begin
            check("pending_job_at_done", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                cmp_e = exp_q.pop_front();
                check("det", det, cmp_e.det);
                check("overflow_flag", overflow_flag, cmp_e.ovf);
                check("size_err", size_err, cmp_e.serr);
                check("busy_low_at_done", busy, 0);
            end
        end
    end

    initial begin
        logic [7:0] d;
        logic       o, s;
        int         lat, n, mode;
        reset = 1'b1; start = 1'b0; size = 3'd0; A_flat = '0;
        repeat (3) @(negedge clock);
        check("rst_det", det, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", overflow_flag, 0);
        check("rst_size_err", size_err, 0);
        reset = 1'b0;

        clr(); set_row(0, 3, 4, 0, 0, 0); set_row(1, 5, 6, 0, 0, 0);
        check("model_pin_2x2", model_det(2, mt), -2);
        run_job(2, 1'b0, 1'b1, d, o, s, lat);
        check("lit_2x2_det", d, 8'hFE);
        check("lit_2x2_ovf", o, 0);
        check("lit_2x2_serr", s, 0);

        clr(); set_row(0, 2, 0, 1, 0, 0); set_row(1, 1, 3, 2, 0, 0); set_row(2, 1, 1, 2, 0, 0);
        check("model_pin_3x3", model_det(3, mt), 6);
        run_job(3, 1'b1, 1'b0, d, o, s, lat);
        check("lit_3x3_det", d, 6);

        clr(); set_row(0, 0, 1, 0, 0, 0); set_row(1, 1, 0, 0, 0, 0);
        set_row(2, 0, 0, 1, 0, 0); set_row(3, 0, 0, 0, 1, 0);
        check("model_pin_perm", model_det(4, mt), -1);
        run_job(4, 1'b0, 1'b0, d, o, s, lat);
        check("lit_perm_det", d, 8'hFF);

        clr(); set_row(0, 1, 1, 1, 0, 0); set_row(1, 1, 1, 1, 0, 0); set_row(2, 1, 1, 1, 0, 0);
        check("model_pin_ones", model_det(3, mt), 0);
        run_job(3, 1'b0, 1'b0, d, o, s, lat);
        check("lit_ones_det", d, 0);
        check("lit_ones_ovf", o, 0);

        clr(); for (int i = 0; i < 5; i++) mt[i][i] = 4;
        check("model_pin_diag4", model_det(5, mt), 1024);
        run_job(5, 1'b1, 1'b1, d, o, s, lat);
        check("lit_diag4_ovf", o, 1);
`ifdef DET_SATURATE_EN
        check("lit_diag4_det", d, 127);
`else
        check("lit_diag4_det", d, 0);
`endif

        clr(); mt[0][0] = -7;
        run_job(1, 1'b0, 1'b0, d, o, s, lat);
        check("lit_n1_det", d, 8'hF9);
        check("latency_n1_in_range", (lat >= 2) && (lat <= 3), 1);

        run_job(0, 1'b0, 1'b0, d, o, s, lat);
        check("lit_size0_serr", s, 1);
        check("lit_size0_det", d, 0);
        run_job(6, 1'b0, 1'b0, d, o, s, lat);
        check("lit_size6_serr", s, 1);

        // Reset in the middle of a long job: no done, outputs cleared, next job correct.
        clr(); set_row(0, 3, 4, 0, 0, 0); set_row(1, 5, 6, 0, 0, 0);
        run_job(2, 1'b0, 1'b0, d, o, s, lat);
        clr(); for (int i = 0; i < 5; i++) mt[i][i] = 4;
        @(negedge clock);
        load(5, mt); start = 1'b1; exp_q.push_back(model_job(5, mt));
        @(negedge clock); start = 1'b0;
        repeat (40) @(negedge clock);
        reset = 1'b1; exp_q.delete();
        @(negedge clock);
        check("midrst_det", det, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ovf", overflow_flag, 0);
        reset = 1'b0;
        clr(); set_row(0, 2, 0, 1, 0, 0); set_row(1, 1, 3, 2, 0, 0); set_row(2, 1, 1, 2, 0, 0);
        run_job(3, 1'b0, 1'b0, d, o, s, lat);
        check("after_rst_det", d, 6);

        for (int t = 0; t < 30; t++) begin
            mode = $urandom_range(0, 15);
            n = (mode == 0) ? 0 : (mode == 1) ? 6 + $urandom_range(0, 1) : 1 + (mode % 5);
            mode = $urandom_range(0, 3);
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    case (mode)
                        0:       mt[r][c] = $urandom_range(0, 255) - 128;
                        1:       mt[r][c] = $urandom_range(0, 4) - 2;
                        2:       mt[r][c] = $urandom_range(0, 1);
                        default: mt[r][c] = $urandom_range(0, 255) - 128;
                    endcase
            if (mode == 3 && n >= 2 && n <= 5)
                for (int c = 0; c < 5; c++) mt[n-1][c] = mt[0][c];
            run_job(n, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, d, o, s, lat);
        end

        repeat (3) @(negedge clock);
        check("no_outstanding_jobs", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
